// File: rtl/keyboard_fifo_ctrl_if.sv
// Bundle of the CPU-bus and PS/2-byte handshake signals around keyboard_fifo_ctrl.
//   master : CPU/PS2-controller side (drives strobes, write data, rx bytes, tx status)
//   slave  : keyboard_fifo_ctrl side (drives read data, interrupt, tx byte/strobe)
//   read/write/addr/in_bus : CPU register access strobes, select and write data
//   out_bus/interrupt      : registered read data and level IRQ
//   rx_data/rx_valid       : received byte handshake from the PS/2 byte controller
//   tx_data/tx_send        : command byte and one-cycle send strobe to the controller
//   tx_done/tx_error       : send-complete / send-failed pulses from the controller
interface keyboard_fifo_ctrl_if #(
    parameter int BUS_W = 16
);
    logic             read;
    logic             write;
    logic             addr;
    logic [BUS_W-1:0] in_bus;
    logic [BUS_W-1:0] out_bus;
    logic             interrupt;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic [7:0]       tx_data;
    logic             tx_send;
    logic             tx_done;
    logic             tx_error;

    modport master (
        output read, write, addr, in_bus, rx_data, rx_valid, tx_done, tx_error,
        input  out_bus, interrupt, tx_data, tx_send
    );

    modport slave (
        input  read, write, addr, in_bus, rx_data, rx_valid, tx_done, tx_error,
        output out_bus, interrupt, tx_data, tx_send
    );
endinterface

// File: rtl/keyboard_fifo_ctrl.sv
// CPU-side PS/2 keyboard port: receive FIFO with overflow tracking, status/control
// registers, interrupt masking, and a command engine that sends a byte, waits for
// the keyboard's ACK (0xFA), resends on 0xFE or send error, and times out.
//   clk   : system clock, all state on posedge
//   rst_n : asynchronous active-low reset
//   bus   : keyboard_fifo_ctrl_if slave modport (CPU bus + PS/2 byte handshakes)
//   Register map: addr 0 = DATA (read pops the FIFO, write starts a command)
//                 addr 1 = STATUS (read) / CTRL (write)
module keyboard_fifo_ctrl #(
    parameter int DEPTH_LOG2  = 5,
    parameter int BUS_W       = 16,
    parameter int ACK_TIMEOUT = 1000000,
    parameter int MAX_RETRY   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    keyboard_fifo_ctrl_if.slave  bus
);
    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int TIMER_W = $clog2(ACK_TIMEOUT + 1);
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [TIMER_W-1:0]  TIMER_LAST  = TIMER_W'(ACK_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0]  RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_TX, WAIT_ACK} state_t;

    state_t                state;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
    logic                  cmd_err;
    logic                  irq_en;
    logic [RETRY_W-1:0]    retry;
    logic [TIMER_W-1:0]    timer;
    logic [7:0]            tx_data_q;
    logic                  tx_send_q;
    logic [BUS_W-1:0]      out_bus_q;

    logic nonempty, full, busy;
    logic data_rd, stat_rd, data_wr, ctrl_wr;
    logic ack_byte, nak_byte, push_req, flush, pop, push, ovf_event;
    logic [BUS_W-1:0] data_word, status_word;
    logic unused_in_bits;

    assign nonempty = (count != '0);
    assign full     = (count == FULL_COUNT);
    assign busy     = (state != IDLE);

    assign data_rd = bus.read  & ~bus.addr;
    assign stat_rd = bus.read  &  bus.addr;
    assign data_wr = bus.write & ~bus.addr;
    assign ctrl_wr = bus.write &  bus.addr;

    // ACK/resend bytes are swallowed by the command engine only while it waits for a reply;
    // at any other time they are ordinary scancodes.
    assign ack_byte = (state == WAIT_ACK) & bus.rx_valid & (bus.rx_data == 8'hFA);
    assign nak_byte = (state == WAIT_ACK) & bus.rx_valid & (bus.rx_data == 8'hFE);
    assign push_req = bus.rx_valid & ~(ack_byte | nak_byte);

    // Flush beats any push or pop in the same cycle. A pop frees a slot, so a push
    // into a full FIFO is accepted when a pop happens alongside it.
    assign flush     = ctrl_wr & bus.in_bus[7];
    assign pop       = data_rd & nonempty & ~flush;
    assign push      = push_req & ~flush & (~full | pop);
    assign ovf_event = push_req & ~flush & full & ~pop;

    assign unused_in_bits = ^{bus.in_bus[BUS_W-1:8], bus.in_bus[6:5], bus.in_bus[3], bus.in_bus[1]};

    always_comb begin
        data_word = '0;
        if (nonempty) begin
            data_word[BUS_W-1] = 1'b1;
            data_word[7:0]     = mem[rd_ptr];
        end
        status_word                   = '0;
        status_word[8+DEPTH_LOG2:8]   = count;
        status_word[5:0]              = {irq_en, cmd_err, busy, overflow, full, nonempty};
    end

    // FIFO storage has no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Read data register and the CTRL-owned flags. A new overflow wins over a
    // same-cycle clear so the event is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_bus_q <= '0;
            overflow  <= 1'b0;
            irq_en    <= 1'b1;
        end else begin
            if (data_rd) begin
                out_bus_q <= data_word;
            end else if (stat_rd) begin
                out_bus_q <= status_word;
            end
            if (ctrl_wr) begin
                irq_en <= bus.in_bus[0];
                if (bus.in_bus[2]) overflow <= 1'b0;
            end
            if (ovf_event) overflow <= 1'b1;
        end
    end

    // Command engine. tx_send is asserted on entry to SEND, so it is high for exactly
    // the one cycle spent in SEND. cmd_err set conditions override a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            retry     <= '0;
            timer     <= '0;
            tx_data_q <= 8'h00;
            tx_send_q <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            tx_send_q <= 1'b0;
            if (ctrl_wr && bus.in_bus[4]) cmd_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_wr) begin
                        tx_data_q <= bus.in_bus[7:0];
                        retry     <= '0;
                        tx_send_q <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    state <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (bus.tx_done) begin
                        timer <= '0;
                        state <= WAIT_ACK;
                    end else if (bus.tx_error) begin
                        if (retry < RETRY_LIMIT) begin
                            retry     <= retry + 1'b1;
                            tx_send_q <= 1'b1;
                            state     <= SEND;
                        end else begin
                            cmd_err <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                end
                WAIT_ACK: begin
                    if (ack_byte) begin
                        state <= IDLE;
                    end else if (nak_byte) begin
                        if (retry < RETRY_LIMIT) begin
                            retry     <= retry + 1'b1;
                            tx_send_q <= 1'b1;
                            state     <= SEND;
                        end else begin
                            cmd_err <= 1'b1;
                            state   <= IDLE;
                        end
                    end else if (timer == TIMER_LAST) begin
                        cmd_err <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (data_wr && state != IDLE) cmd_err <= 1'b1;
        end
    end

    assign bus.out_bus   = out_bus_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_send   = tx_send_q;
    assign bus.interrupt = irq_en & (nonempty | overflow);
endmodule
